dot_product_requant: RTL
========================

// Module: dot_product_requant
//
// PURPOSE
// - Consumer side of the dot-product datapath: takes the signed 32-bit partial sums produced by the
//   dot-product units and turns each vector of them into one 8-bit activation.
// - The 8-bit activation feeds back as an operand byte for the next layer.
// - Per vector: sums the partial-sum beats, adds the bias, applies a rounding arithmetic right shift,
//   then clamps to 8 bits. Valid/ready handshakes on both sides; 2-stage pipeline.
//
// PARAMETERS
// - ACC_W   40  accumulator width in bits, signed; must be >= 33.
// - SHIFT_W 5   width of cfg_shift; shift range is 0..2^SHIFT_W-1.
//
// PORTS
// - clk         in   1        clock; all logic is on the rising edge.
// - rst_n       in   1        asynchronous active-low reset.
// - cfg_bias    in   32       signed bias; sampled on the first beat of each vector.
// - cfg_shift   in   SHIFT_W  right-shift amount; sampled on the last beat of each vector.
// - psum_valid  in   1        partial-sum beat is valid.
// - psum_ready  out  1        block can accept a beat.
// - psum_data   in   32       signed partial sum.
// - psum_last   in   1        this beat is the last one of the vector.
// - res_valid   out  1        result is valid.
// - res_ready   in   1        downstream accepts the result.
// - res_data    out  8        quantized activation.
// - res_sat     out  1        clamping occurred for this result.
//
// BEHAVIOUR
// - Beat handshake: psum_valid & psum_ready. Result handshake: res_valid & res_ready.
// - Reset: every output register is 0 (psum_ready is combinational, so it reads 1 after reset).
//   Reset also clears: acc, the first-beat flag (set to 1), r1_valid and res_valid.
// - Stage A, accumulate. On an accepted beat:
//   - base = first ? sext(cfg_bias) : acc; sum = base + sext(psum_data), computed in ACC_W bits.
//   - Not the last beat: acc <= sum and first <= 0.
//   - Last beat: r1 <= sum, r1_shift <= cfg_shift, r1_valid <= 1, first <= 1.
//   - A vector may be a single beat (first and last together): r1 = bias + psum.
//   - acc wraps modulo 2^ACC_W; overflow is not detected.
// - Stage B, requantize. This stage loads when r1_valid and the output register is free
//   (!res_valid | res_ready):
//   - rnd = (r1_shift == 0) ? r1 : (r1 + (1 << (r1_shift-1))) >>> r1_shift.
//     This is round-half-up with an arithmetic shift.
//   - res_data = clamp(rnd); res_sat = 1 iff clamping changed the value.
//   - res_valid <= 1; r1_valid clears unless a new last beat loads r1 in the same cycle.
// - psum_ready = !r1_valid | stage_B_loads. This is combinational from res_ready.
//   Result: full throughput, 1 beat/clk with res_ready high.
// - Latency: last-beat handshake in cycle t gives res_valid in cycle t+2.
// - res_valid holds, and res_data/res_sat stay stable, until the result handshake.
// - Simultaneous events:
//   - Result taken and a new result loaded in the same cycle: res_valid stays 1 with the new data.
//   - r1 drained and refilled in the same cycle: allowed.
// - Backpressure: with res_ready low, at most 2 results are held (res + r1).
//   After that, psum_ready drops once r1 is full; non-last beats are also stalled.
// - cfg changes while a vector is in progress affect only the sample points defined above.
// - Asynchronous reset mid-vector discards the partial acc and any pending results.
//   The next accepted beat is treated as a first beat.
//
// CONFIGURATION
// - Macro REQUANT_SIGNED_OUT_EN.
// - Undefined (default): ReLU output. Clamp rnd to [0,255], unsigned.
// - Defined: signed output. Clamp rnd to [-128,127]; res_data is two's complement.
// - Pipeline timing and handshakes are identical in both builds.
//
// TESTING
// - bias=0, shift=0; beats 10, 20, 30(last) -> res_data=60, res_sat=0, res_valid 2 clk after the last beat.
// - bias=-100, shift=0; single beat 50(last):
//   - default build -> res_data=0, res_sat=1.
//   - REQUANT_SIGNED_OUT_EN -> res_data=8'hCE (-50), res_sat=0.
// - bias=0, shift=4:
//   - beats 1000, 24(last) -> (1024+8)>>>4 = 64.
//   - single beat 40 -> 3 (the rounding bit is applied).
// - bias=0, shift=2; beat 5000(last) -> 1250 -> res_data=255, res_sat=1.
//   - In signed mode: 127, res_sat=1.
// - res_ready low for 10 clk while 3 one-beat vectors (1, 2, 3) are sent:
//   - psum_ready drops after 2 results are held.
//   - After release, results arrive in order 1, 2, 3 with none lost or duplicated.
// - bias=7; rst_n pulsed low after 2 non-last beats:
//   - All outputs are 0 during reset.
//   - Next vector 5(last) -> res_data=12; the earlier beats are discarded.

Source files
------------

// File: rtl/dot_product_requant.sv
// dot_product_requant: sums signed 32-bit psum beats per vector, adds bias, rounds/shifts and clamps to 8 bits.
// Build option REQUANT_SIGNED_OUT_EN: signed [-128,127] output instead of ReLU [0,255].
module dot_product_requant #(
   parameter int ACC_W   = 40,
   parameter int SHIFT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [31:0]        cfg_bias,
   input  logic [SHIFT_W-1:0] cfg_shift,
   input  logic               psum_valid,
   output logic               psum_ready,
   input  logic [31:0]        psum_data,
   input  logic               psum_last,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [7:0]         res_data,
   output logic               res_sat
);

   // Handshakes: a beat moves on psum_valid & psum_ready, a result on res_valid & res_ready;
   // valid never waits on ready, and res_data/res_sat hold while res_valid is unacknowledged.

`ifdef REQUANT_SIGNED_OUT_EN
   localparam logic signed [ACC_W:0] C_MAX = (ACC_W+1)'(127);
   localparam logic signed [ACC_W:0] C_MIN = (ACC_W+1)'(-128);
`else
   localparam logic signed [ACC_W:0] C_MAX = (ACC_W+1)'(255);
   localparam logic signed [ACC_W:0] C_MIN = '0;
`endif

   logic signed [ACC_W-1:0] r_acc;
   logic                    r_first;
   logic signed [ACC_W-1:0] r_r1;
   logic [SHIFT_W-1:0]      r_r1_shift;
   logic                    r_r1_valid;

   logic                    w_b_load;
   logic                    w_beat;
   logic signed [ACC_W-1:0] w_bias_ext;
   logic signed [ACC_W-1:0] w_psum_ext;
   logic signed [ACC_W-1:0] w_base;
   logic signed [ACC_W-1:0] w_sum;
   logic signed [ACC_W:0]   w_r1_ext;
   logic signed [ACC_W:0]   w_half;
   logic signed [ACC_W:0]   w_rnd;
   logic [7:0]              w_clamp;
   logic                    w_sat;

   assign w_b_load   = r_r1_valid & (~res_valid | res_ready);
   assign psum_ready = ~r_r1_valid | w_b_load;
   assign w_beat     = psum_valid & psum_ready;

   assign w_bias_ext = {{(ACC_W-32){cfg_bias[31]}}, cfg_bias};
   assign w_psum_ext = {{(ACC_W-32){psum_data[31]}}, psum_data};
   assign w_base     = r_first ? w_bias_ext : r_acc;
   assign w_sum      = w_base + w_psum_ext;

   // One extra bit keeps the rounding add from wrapping near the top of the accumulator range.
   assign w_r1_ext = {r_r1[ACC_W-1], r_r1};

   always_comb begin
      w_half = '0;
      if (r_r1_shift != '0)
         w_half = {{ACC_W{1'b0}}, 1'b1} << (r_r1_shift - SHIFT_W'(1));
   end

   assign w_rnd = (w_r1_ext + w_half) >>> r_r1_shift;

   always_comb begin
      w_clamp = w_rnd[7:0];
      w_sat   = 1'b0;
      if (w_rnd > C_MAX) begin
         w_clamp = C_MAX[7:0];
         w_sat   = 1'b1;
      end else if (w_rnd < C_MIN) begin
         w_clamp = C_MIN[7:0];
         w_sat   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc      <= '0;
         r_first    <= 1'b1;
         r_r1       <= '0;
         r_r1_shift <= '0;
         r_r1_valid <= 1'b0;
      end else begin
         if (w_beat) begin
            if (psum_last) begin
               r_r1       <= w_sum;
               r_r1_shift <= cfg_shift;
               r_first    <= 1'b1;
            end else begin
               r_acc   <= w_sum;
               r_first <= 1'b0;
            end
         end
         // A new last beat wins over the drain so r1 can empty and refill in one cycle.
         if (w_beat && psum_last)
            r_r1_valid <= 1'b1;
         else if (w_b_load)
            r_r1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_sat   <= 1'b0;
      end else if (w_b_load) begin
         res_valid <= 1'b1;
         res_data  <= w_clamp;
         res_sat   <= w_sat;
      end else if (res_ready) begin
         res_valid <= 1'b0;
      end
   end

endmodule
